// File: rtl/ascon_out_unpacker.sv
// Serialises 128-bit words from the ascon output FIFO into a byte-exact 32-bit valid/ready stream.
// The last beat of a transfer is trimmed with m_keep/m_last against the programmed length.
module ascon_out_unpacker #(
  parameter int WORD_W      = 128,
  parameter int OUT_W       = 32,
  parameter int RD_LAT      = 1,
  parameter int STALL_LIMIT = 1023
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          len_bytes,
  input  logic [WORD_W-1:0]    fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic [OUT_W-1:0]     m_data,
  output logic [OUT_W/8-1:0]   m_keep,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2:0]           dbg_state
);

  localparam int BEATS = WORD_W / OUT_W;
  localparam int BPB   = OUT_W / 8;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BPB-1:0] KEEP_ALL = '1;
  localparam logic [31:0]    STALL_M1 = 32'(STALL_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  // Stream handshake: a beat transfers on any rising edge where m_valid and m_ready are both 1;
  // m_valid never drops and m_data/m_keep/m_last never change until that beat has transferred.

  state_t            state, state_next;
  logic [15:0]       rem;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] word;
  logic [31:0]       stall_cnt;

  logic              hs;
  logic              last_beat;
  logic              stall_hit;
  logic [WORD_W-1:0] word_sh;
  logic [OUT_W-1:0]  beat;
  logic [BPB-1:0]    keep_w;
  logic [OUT_W-1:0]  byte_mask;

  assign hs        = (state == S_EMIT) && m_ready;
  assign last_beat = (rem <= 16'(BPB));
  assign stall_hit = (STALL_LIMIT != 0) && fifo_empty && (stall_cnt == STALL_M1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = (len_bytes == 16'd0) ? S_FIN : S_FETCH;
      end
      S_FETCH: begin
        if (!fifo_empty)   state_next = (RD_LAT == 0) ? S_EMIT : S_WAIT;
        else if (stall_hit) state_next = S_FIN;
      end
      S_WAIT: state_next = S_EMIT;
      S_EMIT: begin
        if (hs) begin
          if (last_beat)                      state_next = S_FIN;
          else if (idx == IDX_W'(BEATS - 1))  state_next = S_FETCH;
        end
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Transfer bookkeeping: remaining bytes, beat index, buffered word, stall counter, sticky error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem       <= '0;
      idx       <= '0;
      word      <= '0;
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rem       <= len_bytes;
            idx       <= '0;
            stall_cnt <= '0;
            err       <= 1'b0;
          end
        end
        S_FETCH: begin
          if (!fifo_empty) begin
            stall_cnt <= '0;
            idx       <= '0;
            if (RD_LAT == 0) word <= fifo_data;
          end else begin
            stall_cnt <= stall_cnt + 32'd1;
            if (stall_hit) err <= 1'b1;
          end
        end
        S_WAIT: word <= fifo_data;
        S_EMIT: begin
          if (hs) begin
            rem <= last_beat ? 16'd0 : rem - 16'(BPB);
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Beat selection and byte trimming; every output decodes registered state only.
  always_comb begin
    word_sh   = word << (OUT_W * int'(idx));
    beat      = word_sh[WORD_W-1 -: OUT_W];
    keep_w    = last_beat ? ~(KEEP_ALL >> rem) : KEEP_ALL;
    byte_mask = '0;
    for (int b = 0; b < BPB; b++) begin
      byte_mask[OUT_W-1-8*b -: 8] = {8{keep_w[BPB-1-b]}};
    end

    fifo_rd_en = (state == S_FETCH) && !fifo_empty;
    busy       = (state == S_FETCH) || (state == S_WAIT) || (state == S_EMIT);
    done       = (state == S_FIN);
    m_valid    = (state == S_EMIT);
    m_last     = (state == S_EMIT) && last_beat;
    m_keep     = (state == S_EMIT) ? keep_w : '0;
    m_data     = (state == S_EMIT) ? (beat & byte_mask) : '0;
    dbg_state  = state;
  end

endmodule

// File: tb/tb_ascon_out_unpacker.sv
// Directed bench for ascon_out_unpacker: table of single transfers plus hand-built sequences for
// backpressure with a FIFO underrun, stall timeout, zero length and asynchronous reset mid-transfer.
module tb_ascon_out_unpacker;

  localparam int STALL = 8;
  localparam logic [127:0] W0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] W1 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
  localparam logic [127:0] W2 = 128'hE0E1E2E3_F0F1F2F3_12345678_9ABCDEF0;
  localparam logic [127:0] W3 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  // clock / reset
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  len_bytes = '0;
  logic [127:0] fifo_data = '0;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [31:0]  m_data;
  logic [3:0]   m_keep;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic         m_last;
  logic         busy;
  logic         done;
  logic         err;
  logic [2:0]   dbg_state;

  always #5 clock = ~clock;

  ascon_out_unpacker #(
    .WORD_W(128), .OUT_W(32), .RD_LAT(1), .STALL_LIMIT(STALL)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .len_bytes(len_bytes),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // FIFO model with one cycle of read latency
  logic [127:0] fifo_mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clock) begin
    if (fifo_rd_en) begin
      fifo_data <= fifo_mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // scoreboard
  logic [36:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // sink monitor, sampled on the falling edge
  int          rd_cnt = 0, beat_cnt = 0, done_cnt = 0, valid_cnt = 0, fetch_empty_cnt = 0;
  logic        hold_pending = 1'b0;
  logic        last_hs = 1'b0;
  logic [37:0] held = '0;
  logic [36:0] last_beat_seen = '0;

  always @(negedge clock) begin
    if (reset) begin
      hold_pending = 1'b0;
      last_hs      = 1'b0;
    end else begin
      if (fifo_rd_en) rd_cnt++;
      if (done) done_cnt++;
      if (m_valid) valid_cnt++;
      if (dbg_state == 3'd1 && fifo_empty) fetch_empty_cnt++;
      if (hold_pending) check("hold_stable", {m_valid, m_last, m_keep, m_data}, held);
      if (last_hs) check("done_after_last", done, 1'b1);
      last_hs      = 1'b0;
      hold_pending = m_valid && !m_ready;
      held         = {m_valid, m_last, m_keep, m_data};
      if (m_valid && m_ready) begin
        beat_cnt++;
        last_beat_seen = {m_last, m_keep, m_data};
        last_hs        = m_last;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat", {m_last, m_keep, m_data});
        end else begin
          check("beat", {m_last, m_keep, m_data}, exp_q.pop_front());
        end
      end
    end
  end

  // m_ready driver: mode 0 always ready, mode 1 toggles every cycle
  int ready_mode = 0;
  initial begin
    forever begin
      @(posedge clock);
      #1 m_ready = (ready_mode == 1) ? ~m_ready : 1'b1;
    end
  end

  // driver tasks
  task automatic flush_fifo();
    wr_ptr = rd_ptr;
  endtask

  task automatic push_word(input logic [127:0] w);
    fifo_mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Byte-level reference: byte n of the message is byte n%16 (MSB first) of FIFO word n/16.
  task automatic build_exp(input int len);
    int base;
    base = rd_ptr;
    for (int i = 0; i * 4 < len; i++) begin
      logic [31:0]  d;
      logic [3:0]   k;
      logic [127:0] w;
      int           n;
      d = '0;
      k = '0;
      for (int b = 0; b < 4; b++) begin
        n = 4 * i + b;
        if (n < len) begin
          w = fifo_mem[(base + n / 16) & 255];
          d[31-8*b -: 8] = w[127-8*(n%16) -: 8];
          k[3-b] = 1'b1;
        end
      end
      exp_q.push_back({(4 * i + 4 >= len), k, d});
    end
  endtask

  task automatic pulse_start(input int len);
    @(posedge clock);
    #1 len_bytes = len[15:0];
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    @(negedge clock);
    cyc = 1;
    while (!done && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
    end
  endtask

  task automatic run_xfer(input int len, output int cyc, output logic err_at_start);
    pulse_start(len);
    @(negedge clock);
    err_at_start = err;
    cyc = 1;
    while (!done && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
    end
    repeat (2) @(posedge clock);
  endtask

  typedef struct {
    int          len;
    int          n_beats;
    int          n_rd;
    logic [31:0] last_data;
    logic [3:0]  last_keep;
  } vec_t;

  vec_t vecs [7];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          cyc;
    logic        e0;
    int          rd0, beat0, done0, valid0, fe0;

    vecs[0] = '{16, 4, 1, 32'hCCDDEEFF, 4'b1111};
    vecs[1] = '{21, 6, 2, 32'hB0000000, 4'b1000};
    vecs[2] = '{2,  1, 1, 32'h00110000, 4'b1100};
    vecs[3] = '{7,  2, 1, 32'h44556600, 4'b1110};
    vecs[4] = '{35, 9, 3, 32'hE0E1E200, 4'b1110};
    vecs[5] = '{0,  0, 0, 32'h00000000, 4'b0000};
    vecs[6] = '{32, 8, 2, 32'hD0D1D2D3, 4'b1111};

    // reset values
    #2;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 32'h0);
    check("rst_m_keep", m_keep, 4'h0);
    check("rst_flags", {fifo_rd_en, m_last, busy, done, err}, 5'b0);
    check("rst_state", dbg_state, 3'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // table-driven transfers, m_ready held high
    foreach (vecs[v]) begin
      flush_fifo();
      push_word(W0);
      push_word(W1);
      push_word(W2);
      build_exp(vecs[v].len);
      rd0 = rd_cnt; beat0 = beat_cnt; done0 = done_cnt; valid0 = valid_cnt;
      run_xfer(vecs[v].len, cyc, e0);
      check($sformatf("v%0d_beats", v), beat_cnt - beat0, vecs[v].n_beats);
      check($sformatf("v%0d_rd_en", v), rd_cnt - rd0, vecs[v].n_rd);
      check($sformatf("v%0d_left", v), wr_ptr - rd_ptr, 3 - vecs[v].n_rd);
      check($sformatf("v%0d_done_cnt", v), done_cnt - done0, 1);
      check($sformatf("v%0d_exp_left", v), exp_q.size(), 0);
      check($sformatf("v%0d_err", v), err, 1'b0);
      if (vecs[v].n_beats == 0) begin
        check($sformatf("v%0d_valid", v), valid_cnt - valid0, 0);
        check($sformatf("v%0d_done_lat", v), cyc, 1);
      end else begin
        check($sformatf("v%0d_last_beat", v), last_beat_seen,
              {1'b1, vecs[v].last_keep, vecs[v].last_data});
      end
    end

    // backpressure toggling, FIFO empty for 5 fetch cycles before word 2, start while busy ignored
    flush_fifo();
    push_word(W0);
    fifo_mem[wr_ptr[7:0]] = W1;
    build_exp(32);
    rd0 = rd_cnt; beat0 = beat_cnt; fe0 = fetch_empty_cnt;
    ready_mode = 1;
    pulse_start(32);
    #1 len_bytes = 16'd4;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 0;
    @(negedge clock);
    while (!(dbg_state == 3'd1 && fifo_empty && rd_cnt - rd0 == 1) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check("bp_reach_underrun", (cyc < 200), 1'b1);
    repeat (5) @(posedge clock);
    #1 wr_ptr = wr_ptr + 1;
    wait_done(cyc);
    ready_mode = 0;
    repeat (2) @(posedge clock);
    check("bp_beats", beat_cnt - beat0, 8);
    check("bp_rd_en", rd_cnt - rd0, 2);
    check("bp_underrun_cycles", fetch_empty_cnt - fe0, 5);
    check("bp_exp_left", exp_q.size(), 0);
    check("bp_err", err, 1'b0);

    // stall timeout with an empty FIFO, then recovery
    flush_fifo();
    rd0 = rd_cnt; done0 = done_cnt; valid0 = valid_cnt; fe0 = fetch_empty_cnt;
    run_xfer(16, cyc, e0);
    check("stall_err", err, 1'b1);
    check("stall_fetch_cycles", fetch_empty_cnt - fe0, STALL);
    check("stall_valid", valid_cnt - valid0, 0);
    check("stall_rd_en", rd_cnt - rd0, 0);
    check("stall_done", done_cnt - done0, 1);
    repeat (4) @(posedge clock);
    check("stall_err_sticky", {err, busy}, 2'b10);
    push_word(W0);
    build_exp(16);
    beat0 = beat_cnt;
    run_xfer(16, cyc, e0);
    check("stall_err_cleared", e0, 1'b0);
    check("recover_beats", beat_cnt - beat0, 4);
    check("recover_err", err, 1'b0);
    check("recover_exp_left", exp_q.size(), 0);

    // asynchronous reset during beat 2 of a 48-byte transfer
    flush_fifo();
    push_word(W0);
    push_word(W1);
    push_word(W2);
    push_word(W3);
    build_exp(48);
    rd0 = rd_cnt; beat0 = beat_cnt;
    pulse_start(48);
    cyc = 0;
    @(negedge clock);
    while (!(beat_cnt - beat0 == 1 && m_valid) && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("rst_reach_beat2", (cyc < 100), 1'b1);
    #1 reset = 1'b1;
    #1;
    check("arst_m_valid", m_valid, 1'b0);
    check("arst_m_data", {m_data, m_keep}, 36'h0);
    check("arst_flags", {fifo_rd_en, m_last, busy, done, err}, 5'b0);
    check("arst_state", dbg_state, 3'd0);
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    check("arst_words_read", rd_cnt - rd0, 1);
    build_exp(16);
    beat0 = beat_cnt;
    run_xfer(16, cyc, e0);
    check("post_rst_beats", beat_cnt - beat0, 4);
    check("post_rst_last", last_beat_seen, {1'b1, 4'b1111, 32'hD0D1D2D3});
    check("post_rst_left", wr_ptr - rd_ptr, 2);
    check("post_rst_exp_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
